// File: rtl/proc_fetch_unit_if.sv
// rtl/proc_fetch_unit_if.sv - instruction-memory and decode handshake bundle of the fetch unit
interface proc_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_ack;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_ack,
    output instr_valid, instr_out, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_ack,
    input  instr_valid, instr_out, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/proc_fetch_unit.sv
// rtl/proc_fetch_unit.sv - single-instruction fetch FSM (IDLE/REQ/WAIT/HOLD) with PC redirect
// Optional FETCH_TIMEOUT_EN adds a WAIT-cycle counter and the sticky fetch_err output.
module proc_fetch_unit #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  proc_fetch_unit_if.master bus,
  output logic              busy
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic              fetch_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic              discard;
  logic              transfer;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`else
  wire unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  assign transfer = (state == S_HOLD) && bus.instr_ready && !pc_load;
  assign busy     = (state != S_IDLE);

  // A redirect always wins over the sequential increment.
  always_comb begin
    pc_nxt = pc;
    if (pc_load)
      pc_nxt = pc_load_value;
    else if (transfer)
      pc_nxt = pc + ADDR_W'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      pc              <= RESET_PC;
      discard         <= 1'b0;
      bus.imem_req    <= 1'b0;
      bus.imem_addr   <= RESET_PC;
      bus.instr_valid <= 1'b0;
      bus.instr_out   <= '0;
      bus.instr_pc    <= '0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt         <= '0;
      fetch_err       <= 1'b0;
`endif
    end else begin
      pc <= pc_nxt;
      unique case (state)
        S_IDLE: begin
          if (fetch_start) begin
            state         <= S_REQ;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= pc_nxt;
          end
        end
        S_REQ, S_WAIT: begin
          if (bus.imem_ack) begin
            if (discard || pc_load) begin
              // Stale data from before a redirect: reissue at the new PC.
              state         <= S_REQ;
              bus.imem_addr <= pc_nxt;
              discard       <= 1'b0;
            end else begin
              state           <= S_HOLD;
              bus.imem_req    <= 1'b0;
              bus.instr_valid <= 1'b1;
              bus.instr_out   <= bus.imem_rdata;
              bus.instr_pc    <= pc;
            end
          end else begin
            state <= S_WAIT;
            if (pc_load)
              discard <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            if (state == S_REQ) begin
              tmo_cnt <= '0;
            end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
              state        <= S_IDLE;
              bus.imem_req <= 1'b0;
              discard      <= 1'b0;
              fetch_err    <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
`endif
          end
        end
        S_HOLD: begin
          if (pc_load) begin
            state           <= S_IDLE;
            bus.instr_valid <= 1'b0;
          end else if (bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
            if (fetch_start) begin
              state         <= S_REQ;
              bus.imem_req  <= 1'b1;
              bus.imem_addr <= pc_nxt;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/proc_fetch_unit.md
PROC_FETCH_UNIT -- requirements
Module: proc_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and instruction-memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum wait for imem_ack, used only with FETCH_TIMEOUT_EN.
REQ-005 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port fetch_start  input  1  pulse from the controller in its Fetch state that requests one instruction.
REQ-008 SHALL have port pc_load  input  1  redirects the PC for a branch or jump taken in writeback.
REQ-009 SHALL have port pc_load_value  input  ADDR_W  target PC for pc_load.
REQ-010 SHALL have port imem_req  output  1  instruction-memory request.
REQ-011 SHALL have port imem_addr  output  ADDR_W  instruction-memory address.
REQ-012 SHALL have port imem_rdata  input  DATA_W  instruction-memory read data, valid when imem_ack=1.
REQ-013 SHALL have port imem_ack  input  1  instruction-memory acknowledge.
REQ-014 SHALL have port instr_valid  output  1  instr_out holds an instruction for decode.
REQ-015 SHALL have port instr_ready  input  1  decode accepts instr_out.
REQ-016 SHALL have port instr_out  output  DATA_W  fetched instruction.
REQ-017 SHALL have port instr_pc  output  ADDR_W  PC of instr_out.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.
REQ-019 SHALL have port fetch_err  output  1  sticky timeout flag; present only with FETCH_TIMEOUT_EN.

Function
REQ-020 SHALL implement a four-state FSM: IDLE, REQ, WAIT, HOLD.
REQ-021 In IDLE, fetch_start=1 SHALL move the FSM to REQ on the next cycle; otherwise it SHALL stay in IDLE.
REQ-022 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal the PC; the FSM SHALL move to WAIT the next cycle, or directly to HOLD if imem_ack=1 in that cycle.
REQ-023 In WAIT, imem_req SHALL stay 1 with a stable imem_addr until imem_ack=1; the FSM SHALL then move to HOLD.
REQ-024 On the cycle with imem_ack=1, instr_out SHALL capture imem_rdata and instr_pc SHALL capture the PC; the minimum latency from fetch_start to instr_valid is 2 cycles.
REQ-025 In HOLD, instr_valid SHALL be 1 with instr_out and instr_pc stable; the transfer completes when instr_valid and instr_ready are both 1.
REQ-026 On transfer, the PC SHALL advance by 4 modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0; the FSM SHALL move to IDLE, or to REQ if fetch_start=1 in the same cycle.
REQ-027 pc_load=1 SHALL set the PC to pc_load_value on the next edge and SHALL take priority over the +4 increment in the same cycle.
REQ-028 pc_load in REQ or WAIT SHALL NOT cut the outstanding request short; imem_addr SHALL stay stable until imem_ack, and the data returned SHALL be discarded with the FSM returning to REQ at the new PC.
REQ-029 pc_load in HOLD SHALL drop instr_valid on the next cycle and return the FSM to IDLE; the instruction is not delivered.
REQ-030 fetch_start outside IDLE, and outside the HOLD transfer cycle, SHALL be ignored.
REQ-031 imem_ack in IDLE or HOLD SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for a clock edge, force FSM=IDLE, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, busy=0, fetch_err=0, and timeout counter=0.
REQ-033 Reset in WAIT SHALL abandon the request; a late imem_ack after release SHALL be ignored because the FSM is in IDLE.

Configuration
REQ-034 With macro FETCH_TIMEOUT_EN defined, a counter SHALL count WAIT cycles; when TIMEOUT_CYCLES cycles pass without imem_ack, fetch_err SHALL be set (sticky until reset), imem_req SHALL drop, and the FSM SHALL return to IDLE.
REQ-035 With FETCH_TIMEOUT_EN undefined, neither the port fetch_err nor the counter SHALL exist, and WAIT SHALL wait indefinitely.

Verification
REQ-036 Reset release, then fetch_start, with imem_ack one cycle after imem_req and rdata=0x00A00093 -> instr_valid=1 two cycles after fetch_start, instr_out=0x00A00093, instr_pc=0.
REQ-037 Hold instr_ready=0 for 5 cycles in HOLD -> instr_valid, instr_out and instr_pc stay stable; on instr_ready=1 the PC becomes 4.
REQ-038 pc_load=1 with value 0x100 during WAIT, then imem_ack -> first data discarded, a new imem_req is issued at 0x100, and the instr_pc delivered is 0x100.
REQ-039 Preload PC=0xFFFFFFFC, then fetch and accept -> the next imem_addr is 0x0.
REQ-040 With FETCH_TIMEOUT_EN, no ack for 16 cycles -> fetch_err=1, imem_req=0, busy=0; rst_n=0 then clears fetch_err.
REQ-041 Assert rst_n=0 mid-WAIT between clock edges -> imem_req=0 at once, and an ack after release produces no instr_valid.
